base_param_rd: RTL and testbench



---
 rtl/base_param_rd_if.sv | 21 ++
 rtl/base_param_rd.sv | 122 ++++++++++++
 tb/tb_base_param_rd.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/base_param_rd_if.sv
// BRAM-controller read port between the parameter fetcher (master) and the
// parameter BRAM (slave).
interface base_param_rd_if;
  logic        ram_clk;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic        ram_en;
  logic [31:0] ram_rd_data;
  logic [3:0]  ram_we;
  logic [31:0] ram_wd_data;

  modport master (
    output ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data,
    input  ram_rd_data
  );

  modport slave (
    input  ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data,
    output ram_rd_data
  );
endinterface

// File: rtl/base_param_rd.sv
// Fetches NUM_WORDS consecutive 32-bit words from the parameter BRAM starting
// at START_ADDR and holds them for the accelerator control logic.
module base_param_rd #(
  parameter logic [31:0] START_ADDR = 32'h4580_0000,
  parameter int unsigned NUM_WORDS  = 4,
  parameter logic [31:0] ADDR_STEP  = 32'd4,
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  base_param_rd_if.master           ram,
  output logic [32*NUM_WORDS-1:0]   param_data,
  output logic                      busy,
  output logic                      Transfer_Done
);

  localparam int unsigned    IDXW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  auto_q;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [IDXW-1:0]       tag_idx_q [RD_LATENCY];
  logic [32*NUM_WORDS-1:0] param_q;

  logic            trigger;
  logic            cap_vld;
  logic [IDXW-1:0] cap_idx;
  logic            last_cap;

  // auto_q stands in for a start pulse on the first cycle out of reset
  assign trigger  = ((state_q == IDLE) || (state_q == DONE)) && (start || auto_q);
  assign cap_vld  = tag_vld_q[RD_LATENCY-1];
  assign cap_idx  = tag_idx_q[RD_LATENCY-1];
  assign last_cap = cap_vld && (cap_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      addr_q      <= '0;
      en_q        <= 1'b0;
      auto_q      <= AUTO_START;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      auto_q      <= 1'b0;
    end
  end

  // Address/enable are registered from the next state so the request for
  // word k is on the port in the same cycle the FSM sits in ISSUE for k.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    addr_d      = '0;
    en_d        = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (trigger) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
          addr_d      = START_ADDR;
          en_d        = 1'b1;
        end
      end
      ISSUE: begin
        if (issue_cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          addr_d      = addr_q + ADDR_STEP;
          en_d        = 1'b1;
        end
      end
      DRAIN: begin
        if (last_cap) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ISSUE) || (state_q == DRAIN);
    Transfer_Done = (state_q == DONE);
  end

  // Tag pipe mirrors the BRAM read latency so each word lands in its own slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_idx_q[i] <= '0;
      param_q   <= '0;
    end else begin
      tag_vld_q[0] <= en_q;
      tag_idx_q[0] <= issue_cnt_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      if (cap_vld) param_q[32*int'(cap_idx) +: 32] <= ram.ram_rd_data;
    end
  end

  assign param_data      = param_q;
  assign ram.ram_clk     = clk;
  assign ram.ram_rst     = 1'b0;
  assign ram.ram_addr    = addr_q;
  assign ram.ram_en      = en_q;
  assign ram.ram_we      = '0;
  assign ram.ram_wd_data = '0;

endmodule

// File: tb/tb_base_param_rd.sv
// Directed bench for base_param_rd: default build, a 3-cycle-latency two-word
// build without auto-start, and a build whose address range wraps past 2^32.
module tb_base_param_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, start0, start1, start2;
  logic [127:0] pd0, pd2;
  logic [63:0]  pd1;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [31:0] mem0 [4];
  logic [31:0] p1a, p1b;
  int unsigned errors = 0;
  int unsigned checks = 0;

  base_param_rd_if bus0 ();
  base_param_rd_if bus1 ();
  base_param_rd_if bus2 ();

  base_param_rd dut0 (
    .clk(clk), .rst(rst0), .start(start0), .ram(bus0),
    .param_data(pd0), .busy(busy0), .Transfer_Done(done0)
  );

  base_param_rd #(.NUM_WORDS(2), .RD_LATENCY(3), .AUTO_START(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .ram(bus1),
    .param_data(pd1), .busy(busy1), .Transfer_Done(done1)
  );

  base_param_rd #(.START_ADDR(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst1), .start(start2), .ram(bus2),
    .param_data(pd2), .busy(busy2), .Transfer_Done(done2)
  );

  function automatic logic [31:0] rd_mem0(input logic [31:0] a);
    return (a[31:4] == 28'h4580000) ? mem0[a[3:2]] : 32'hBAD0_BAD0;
  endfunction

  // BRAM models; idle cycles return a poison word that must never be captured
  always @(posedge clk) begin
    bus0.ram_rd_data <= bus0.ram_en ? rd_mem0(bus0.ram_addr) : 32'hDEAD_BEEF;
    p1a <= !bus1.ram_en ? 32'hDEAD_BEEF :
           (bus1.ram_addr == 32'h4580_0000) ? 32'h55 :
           (bus1.ram_addr == 32'h4580_0004) ? 32'h66 : 32'hBAD0_BAD0;
    p1b <= p1a;
    bus1.ram_rd_data <= p1b;
    bus2.ram_rd_data <= bus2.ram_en ? (bus2.ram_addr ^ 32'h5A5A_5A5A) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] addr2_exp [4];
    addr2_exp[0] = 32'hFFFF_FFF8; addr2_exp[1] = 32'hFFFF_FFFC;
    addr2_exp[2] = 32'h0000_0000; addr2_exp[3] = 32'h0000_0004;
    mem0[0] = 32'h11; mem0[1] = 32'h22; mem0[2] = 32'h33; mem0[3] = 32'h44;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b1; start2 = 1'b0;

    // reset state; start1 high alongside reset must be lost
    repeat (3) tick();
    chk("rst_en", bus0.ram_en, 1'b0);
    chk("rst_addr", bus0.ram_addr, 32'h0);
    chk("rst_pd", pd0, 128'h0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("ram_we", bus0.ram_we, 4'h0);
    chk("ram_wd", bus0.ram_wd_data, 32'h0);
    chk("ram_rst", bus0.ram_rst, 1'b0);
    chk("ram_clk", bus0.ram_clk, clk);

    // cycle 0: first cycle out of reset
    rst0 = 1'b0; rst1 = 1'b0; start1 = 1'b0;
    chk("c0_en", bus0.ram_en, 1'b0);

    // cycles 1..4: ISSUE; extra start in cycle 2 must be ignored
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 2) start0 = 1'b0;
      chk("iss_en", bus0.ram_en, 1'b1);
      chk("iss_addr", bus0.ram_addr, 32'h4580_0000 + 32'(4 * k));
      chk("iss_busy", busy0, 1'b1);
      chk("iss_done", done0, 1'b0);
      chk("wrap_addr", bus2.ram_addr, addr2_exp[k]);
      if (k == 0) chk("lost_start", busy1, 1'b0);
      if (k == 1) start0 = 1'b1;
    end

    tick(); // cycle 5: DRAIN
    chk("c5_en", bus0.ram_en, 1'b0);
    chk("c5_addr", bus0.ram_addr, 32'h0);
    chk("c5_busy", busy0, 1'b1);
    chk("c5_done", done0, 1'b0);

    tick(); // cycle 6: DONE
    chk("c6_done", done0, 1'b1);
    chk("c6_busy", busy0, 1'b0);
    chk("c6_pd", pd0, 128'h00000044_00000033_00000022_00000011);
    chk("wrap_done", done2, 1'b1);
    chk("wrap_pd", pd2, 128'h5A5A5A5E_5A5A5A5A_A5A5A5A6_A5A5A5A2);

    tick(); // cycle 7
    chk("c7_done", done0, 1'b1);
    chk("c7_en", bus0.ram_en, 1'b0);

    repeat (3) tick(); // cycle 10
    start1 = 1'b1;
    mem0[1] = 32'hAA;

    tick(); // cycle 11
    start1 = 1'b0;
    chk("l3_en11", bus1.ram_en, 1'b1);
    chk("l3_addr11", bus1.ram_addr, 32'h4580_0000);
    chk("l3_busy11", busy1, 1'b1);

    tick(); // cycle 12; dut0 restart trigger
    chk("l3_addr12", bus1.ram_addr, 32'h4580_0004);
    start0 = 1'b1;

    tick(); // cycle 13
    start0 = 1'b0;
    chk("l3_en13", bus1.ram_en, 1'b0);
    chk("l3_pd13", pd1, 64'h0);
    chk("re_done", done0, 1'b0);
    chk("re_busy", busy0, 1'b1);
    chk("re_addr", bus0.ram_addr, 32'h4580_0000);

    tick(); // cycle 14
    chk("l3_nocap13", pd1, 64'h0);

    tick(); // cycle 15
    chk("l3_pd15", pd1, 64'h00000000_00000055);
    chk("l3_done15", done1, 1'b0);
    chk("re_pd_old", pd0, 128'h00000044_00000033_00000022_00000011);

    tick(); // cycle 16
    chk("l3_pd16", pd1, 64'h00000066_00000055);
    chk("l3_done16", done1, 1'b1);
    chk("l3_busy16", busy1, 1'b0);
    chk("re_pd_new", pd0, 128'h00000044_00000033_000000AA_00000011);

    tick(); // cycle 17
    chk("re_done17", done0, 1'b0);
    tick(); // cycle 18
    chk("re_done18", done0, 1'b1);
    chk("re_busy18", busy0, 1'b0);

    repeat (2) tick(); // cycle 20
    start0 = 1'b1;
    tick(); // cycle 21
    start0 = 1'b0;
    repeat (2) tick(); // cycle 23: ISSUE cycle 3, reset with a competing start
    chk("mid_addr", bus0.ram_addr, 32'h4580_0008);
    rst0 = 1'b1;
    start0 = 1'b1;

    tick(); // cycle 24
    rst0 = 1'b0;
    start0 = 1'b0;
    chk("mr_en", bus0.ram_en, 1'b0);
    chk("mr_addr", bus0.ram_addr, 32'h0);
    chk("mr_pd", pd0, 128'h0);
    chk("mr_busy", busy0, 1'b0);
    chk("mr_done", done0, 1'b0);

    tick(); // cycle 25: auto-start refetch
    chk("ar_en", bus0.ram_en, 1'b1);
    chk("ar_addr", bus0.ram_addr, 32'h4580_0000);
    chk("ar_busy", busy0, 1'b1);

    repeat (4) tick(); // cycle 29
    chk("ar_done29", done0, 1'b0);
    tick(); // cycle 30
    chk("ar_done30", done0, 1'b1);
    chk("ar_pd", pd0, 128'h00000044_00000033_000000AA_00000011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
